// File: rtl/dp_pix_pack2.sv
// Packs pairs of pixels into a 2*dw word and tracks x/y position within each frame.
// The optional frame-size check (err_w/err_h) is built only when DP_PIX_PACK2_SIZE_CHK_EN is defined.
module dp_pix_pack2 #(
    parameter int dw     = 10,
    parameter int tile_w = 960,
    parameter int tile_h = 540,
    parameter int xw     = 11,
    parameter int yw     = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            soft_rst,
    input  logic            op_st,
    input  logic [dw-1:0]   pix_in,
    input  logic            rdy_in,
    input  logic            last_pix_in,
    input  logic            last_line_in,
    output logic            req_out,
    output logic [2*dw-1:0] pix_out,
    output logic            half_out,
    output logic            rdy_out,
    input  logic            req_in,
    output logic            last_pix_out,
    output logic            last_line_out,
    output logic            frm_done,
    output logic            err_w,
    output logic            err_h,
    output logic            dbg_state,
    output logic [xw-1:0]   dbg_x_cnt,
    output logic [yw-1:0]   dbg_y_cnt
);

    // Handshake: on each side a word moves on the rising edge where the valid
    // (rdy_in upstream, rdy_out downstream) and the ready (req_out upstream,
    // req_in downstream) are both high. Once raised, rdy_out holds with stable
    // data until it is accepted.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    logic [xw-1:0] x_cnt;
    logic [yw-1:0] y_cnt;
    logic [dw-1:0] lo;
    logic          lo_vld;
    logic          in_xfer;
    logic          out_xfer;
    logic          load_out;

    assign req_out  = (state == RUN) & (!rdy_out | req_in);
    // A restart pulse wins over a pixel offered in the same cycle.
    assign in_xfer  = rdy_in & req_out & !op_st;
    assign out_xfer = rdy_out & req_in;
    assign load_out = in_xfer & (lo_vld | last_pix_in);

    assign dbg_state = (state == RUN);
    assign dbg_x_cnt = x_cnt;
    assign dbg_y_cnt = y_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            x_cnt         <= '0;
            y_cnt         <= '0;
            lo            <= '0;
            lo_vld        <= 1'b0;
            rdy_out       <= 1'b0;
            pix_out       <= '0;
            half_out      <= 1'b0;
            last_pix_out  <= 1'b0;
            last_line_out <= 1'b0;
            frm_done      <= 1'b0;
        end else if (soft_rst) begin
            state         <= IDLE;
            x_cnt         <= '0;
            y_cnt         <= '0;
            lo            <= '0;
            lo_vld        <= 1'b0;
            rdy_out       <= 1'b0;
            pix_out       <= '0;
            half_out      <= 1'b0;
            last_pix_out  <= 1'b0;
            last_line_out <= 1'b0;
            frm_done      <= 1'b0;
        end else begin
            frm_done <= out_xfer & last_pix_out & last_line_out;

            // A reload in the same cycle as a drain keeps rdy_out high with new data.
            if (load_out) begin
                rdy_out       <= 1'b1;
                pix_out       <= lo_vld ? {pix_in, lo} : {pix_in, pix_in};
                half_out      <= !lo_vld;
                last_pix_out  <= last_pix_in;
                last_line_out <= last_line_in;
            end else if (out_xfer) begin
                rdy_out <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (op_st) begin
                        state  <= RUN;
                        x_cnt  <= '0;
                        y_cnt  <= '0;
                        lo_vld <= 1'b0;
                    end
                end
                RUN: begin
                    if (op_st) begin
                        x_cnt  <= '0;
                        y_cnt  <= '0;
                        lo_vld <= 1'b0;
                    end else if (in_xfer) begin
                        if (last_pix_in) begin
                            x_cnt  <= '0;
                            lo_vld <= 1'b0;
                            if (last_line_in) begin
                                y_cnt <= '0;
                                state <= IDLE;
                            end else begin
                                y_cnt <= y_cnt + 1'b1;
                            end
                        end else begin
                            x_cnt  <= x_cnt + 1'b1;
                            lo_vld <= !lo_vld;
                            if (!lo_vld) lo <= pix_in;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DP_PIX_PACK2_SIZE_CHK_EN
    // One extra bit keeps an all-ones counter from wrapping into a false match.
    logic [xw:0] x_nxt;
    logic [yw:0] y_nxt;

    assign x_nxt = {1'b0, x_cnt} + (xw+1)'(1);
    assign y_nxt = {1'b0, y_cnt} + (yw+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_w <= 1'b0;
            err_h <= 1'b0;
        end else if (soft_rst | op_st) begin
            err_w <= 1'b0;
            err_h <= 1'b0;
        end else if (in_xfer & last_pix_in) begin
            if (x_nxt != (xw+1)'(tile_w)) err_w <= 1'b1;
            if (last_line_in && (y_nxt != (yw+1)'(tile_h))) err_h <= 1'b1;
        end
    end
`else
    assign err_w = 1'b0;
    assign err_h = 1'b0;
`endif

endmodule

// File: tb/tb_dp_pix_pack2.sv
// Bench for dp_pix_pack2 on a 4x2 tile: cycle table, corner sequences and random frames.
// Error-flag expectations follow DP_PIX_PACK2_SIZE_CHK_EN.
module tb_dp_pix_pack2;
    localparam int DW = 10;
    localparam int TW = 4;
    localparam int TH = 2;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int W  = 2*DW + 3;
`ifdef DP_PIX_PACK2_SIZE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic soft_rst = 1'b0;
    logic op_st = 1'b0;
    logic rdy_in = 1'b0;
    logic last_pix_in = 1'b0;
    logic last_line_in = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic req_hold = 1'b1;
    logic req_rand = 1'b1;
    logic bp_en = 1'b0;
    logic req_in;
    assign req_in = bp_en ? req_rand : req_hold;

    logic            req_out, half_out, rdy_out, last_pix_out, last_line_out;
    logic            frm_done, err_w, err_h, dbg_state;
    logic [2*DW-1:0] pix_out;
    logic [XW-1:0]   dbg_x_cnt;
    logic [YW-1:0]   dbg_y_cnt;

    dp_pix_pack2 #(.dw(DW), .tile_w(TW), .tile_h(TH), .xw(XW), .yw(YW)) dut (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .op_st(op_st),
        .pix_in(pix_in), .rdy_in(rdy_in), .last_pix_in(last_pix_in),
        .last_line_in(last_line_in), .req_out(req_out), .pix_out(pix_out),
        .half_out(half_out), .rdy_out(rdy_out), .req_in(req_in),
        .last_pix_out(last_pix_out), .last_line_out(last_line_out),
        .frm_done(frm_done), .err_w(err_w), .err_h(err_h),
        .dbg_state(dbg_state), .dbg_x_cnt(dbg_x_cnt), .dbg_y_cnt(dbg_y_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(negedge clk) req_rand = ($urandom_range(0, 3) != 0);
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;
    int frm_cnt = 0;
    int exp_frm = 0;
    int stall_cnt = 0;
    bit mon_en = 1'b0;
    bit prev_hold = 1'b0;
    bit exp_ew, exp_eh;
    logic [W-1:0] prev_beat;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic op, rdy; logic [DW-1:0] pix; logic lp, ll, rq;
        logic e_req, e_rdy, c_pix; logic [2*DW-1:0] e_pix;
        logic e_half, e_lp, e_ll, e_fd;
    } vec_t;
    vec_t tv[$];

    function automatic logic [W-1:0] bt(input logic h, input logic lp, input logic ll,
                                        input logic [2*DW-1:0] px);
        return {h, lp, ll, px};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int op, input int rdy, input int pix, input int lp, input int ll,
                       input int rq, input int e_req, input int e_rdy, input int c_pix,
                       input int e_hi, input int e_lo, input int e_half, input int e_lp,
                       input int e_ll, input int e_fd);
        vec_t r;
        r.op = 1'(op); r.rdy = 1'(rdy); r.pix = DW'(pix); r.lp = 1'(lp); r.ll = 1'(ll);
        r.rq = 1'(rq); r.e_req = 1'(e_req); r.e_rdy = 1'(e_rdy); r.c_pix = 1'(c_pix);
        r.e_pix = {DW'(e_hi), DW'(e_lo)}; r.e_half = 1'(e_half); r.e_lp = 1'(e_lp);
        r.e_ll = 1'(e_ll); r.e_fd = 1'(e_fd);
        tv.push_back(r);
    endtask

    // driver tasks: all are entered and left just after a falling edge
    task automatic send_pix(input logic [DW-1:0] p, input logic lp, input logic ll);
        int n;
        n = 0;
        rdy_in = 1'b1; pix_in = p; last_pix_in = lp; last_line_in = ll;
        #1;
        while (!req_out && n < 300) begin
            stall_cnt++;
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_out) begin
            tests++; fails++;
            $display("FAIL send_timeout: req_out stayed 0, required 1");
        end
        @(negedge clk);
    endtask

    task automatic pulse_op(input bit keep_pix);
        if (!keep_pix) rdy_in = 1'b0;
        op_st = 1'b1;
        @(negedge clk);
        op_st = 1'b0;
        rdy_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        rdy_in = 1'b0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain_left", 32'(exp_q.size()), 0);
    endtask

    // reference model: a line of L pixels gives ceil(L/2) beats, the tail of an odd line duplicated
    task automatic run_frame(input int nl, input int fixed_len, input bit gaps);
        int lens[3];
        logic [DW-1:0] px[8];
        bit ew, lastl;
        ew = 1'b0;
        for (int l = 0; l < nl; l++)
            lens[l] = (fixed_len > 0) ? fixed_len :
                      ($urandom_range(0, 1) != 0 ? TW : int'($urandom_range(1, 6)));
        for (int l = 0; l < nl; l++) begin
            lastl = (l == nl - 1);
            if (lens[l] != TW) ew = 1'b1;
            for (int i = 0; i < lens[l]; i++) px[i] = DW'($urandom_range(0, 1023));
            for (int k = 0; 2*k < lens[l]; k++) begin
                if (2*k + 1 < lens[l])
                    exp_q.push_back(bt(1'b0, (2*k + 2 == lens[l]), lastl, {px[2*k+1], px[2*k]}));
                else
                    exp_q.push_back(bt(1'b1, 1'b1, lastl, {px[2*k], px[2*k]}));
            end
            for (int i = 0; i < lens[l]; i++) begin
                if (gaps) begin
                    rdy_in = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                send_pix(px[i], (i == lens[l] - 1), lastl);
            end
        end
        exp_frm++;
        exp_ew = CHK & ew;
        exp_eh = CHK & (nl != TH);
    endtask

    // scoreboard: checks every accepted beat and that a stalled beat holds
    task automatic monitor();
        logic [W-1:0] cur;
        forever begin
            @(negedge clk);
            #2;
            if (frm_done) frm_cnt++;
            cur = bt(half_out, last_pix_out, last_line_out, pix_out);
            if (!mon_en) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_vld", 32'(rdy_out), 1);
                    check("hold_data", 32'(cur), 32'(prev_beat));
                end
                if (rdy_out && req_in) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL beat_unexpected: got 0x%0h, expected no beat", cur);
                    end else begin
                        check("beat", 32'(cur), 32'(exp_q.pop_front()));
                    end
                end
                prev_hold = rdy_out && !req_in;
                prev_beat = cur;
            end
        end
    endtask

    initial begin
        bit seen;
        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_out", 32'(req_out), 0);
        check("rst_rdy_out", 32'(rdy_out), 0);
        check("rst_pix_out", 32'(pix_out), 0);
        check("rst_flags", 32'({half_out, last_pix_out, last_line_out, frm_done}), 0);
        check("rst_err", 32'({err_w, err_h}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4x2 frame of pixels 1..8, then a 5-cycle backpressure stall
        add(1,0, 0,0,0,1, 0,0,0,  0, 0,0,0,0,0);
        add(0,1, 1,0,0,1, 1,0,0,  0, 0,0,0,0,0);
        add(0,1, 2,0,0,1, 1,0,0,  0, 0,0,0,0,0);
        add(0,1, 3,0,0,1, 1,1,1,  2, 1,0,0,0,0);
        add(0,1, 4,1,0,1, 1,0,0,  0, 0,0,0,0,0);
        add(0,1, 5,0,1,1, 1,1,1,  4, 3,0,1,0,0);
        add(0,1, 6,0,1,1, 1,0,0,  0, 0,0,0,0,0);
        add(0,1, 7,0,1,1, 1,1,1,  6, 5,0,0,1,0);
        add(0,1, 8,1,1,1, 1,0,0,  0, 0,0,0,0,0);
        add(0,0, 0,0,0,1, 0,1,1,  8, 7,0,1,1,0);
        add(0,0, 0,0,0,1, 0,0,0,  0, 0,0,0,0,1);
        add(0,0, 0,0,0,1, 0,0,0,  0, 0,0,0,0,0);
        add(1,0, 0,0,0,1, 0,0,0,  0, 0,0,0,0,0);
        add(0,1,11,0,0,1, 1,0,0,  0, 0,0,0,0,0);
        add(0,1,12,0,0,1, 1,0,0,  0, 0,0,0,0,0);
        for (int i = 0; i < 5; i++)
            add(0,0, 0,0,0,0, 0,1,1, 12,11,0,0,0,0);
        add(0,1,13,0,0,1, 1,1,1, 12,11,0,0,0,0);
        add(0,1,14,1,0,1, 1,0,0,  0, 0,0,0,0,0);
        add(0,0, 0,0,0,1, 1,1,1, 14,13,0,1,0,0);
        add(0,0, 0,0,0,1, 1,0,0,  0, 0,0,0,0,0);
        for (int i = 0; i < tv.size(); i++) begin
            op_st = tv[i].op; rdy_in = tv[i].rdy; pix_in = tv[i].pix;
            last_pix_in = tv[i].lp; last_line_in = tv[i].ll; req_hold = tv[i].rq;
            #1;
            check($sformatf("tv%0d_req_out", i), 32'(req_out), 32'(tv[i].e_req));
            check($sformatf("tv%0d_rdy_out", i), 32'(rdy_out), 32'(tv[i].e_rdy));
            check($sformatf("tv%0d_frm_done", i), 32'(frm_done), 32'(tv[i].e_fd));
            if (tv[i].c_pix) begin
                check($sformatf("tv%0d_pix_out", i), 32'(pix_out), 32'(tv[i].e_pix));
                check($sformatf("tv%0d_flags", i), 32'({half_out, last_pix_out, last_line_out}),
                      32'({tv[i].e_half, tv[i].e_lp, tv[i].e_ll}));
            end
            @(negedge clk);
        end
        op_st = 1'b0; rdy_in = 1'b0; req_hold = 1'b1;
        #1;
        check("tv_err", 32'({err_w, err_h}), 0);

        mon_en = 1'b1;
        fork monitor(); join_none

        // 3-pixel line ending the frame: one pair then a half beat
        @(negedge clk);
        pulse_op(1'b0);
        exp_q.push_back(bt(1'b0, 1'b0, 1'b0, {10'd20, 10'd10}));
        exp_q.push_back(bt(1'b1, 1'b1, 1'b1, {10'd30, 10'd30}));
        send_pix(10'd10, 1'b0, 1'b0);
        send_pix(10'd20, 1'b0, 1'b0);
        send_pix(10'd30, 1'b1, 1'b1);
        exp_frm++;
        wait_drain();
        check("odd_err_w", 32'(err_w), 32'(CHK));
        check("odd_err_h", 32'(err_h), 32'(CHK));

        // restart with a held lo pixel and a pixel offered under op_st
        pulse_op(1'b0);
        send_pix(10'h3FF, 1'b0, 1'b0);
        rdy_in = 1'b1; pix_in = 10'h155; last_pix_in = 1'b0; last_line_in = 1'b0;
        pulse_op(1'b1);
        #1;
        check("restart_x_cnt", 32'(dbg_x_cnt), 0);
        check("restart_state", 32'(dbg_state), 1);
        exp_q.push_back(bt(1'b0, 1'b0, 1'b0, {10'd2, 10'd1}));
        send_pix(10'd1, 1'b0, 1'b0);
        send_pix(10'd2, 1'b0, 1'b0);
        wait_drain();
        check("restart_x_after", 32'(dbg_x_cnt), 2);

        // three full lines on a two-line tile, req_in high throughout
        pulse_op(1'b0);
        stall_cnt = 0;
        run_frame(3, TW, 1'b0);
        check("full_tp_stalls", 32'(stall_cnt), 0);
        wait_drain();
        check("lines3_err_h", 32'(err_h), 32'(exp_eh));
        check("lines3_err_w", 32'(err_w), 32'(exp_ew));
        repeat (5) @(negedge clk);
        check("lines3_err_h_sticky", 32'(err_h), 32'(exp_eh));
        pulse_op(1'b0);
        #1;
        check("op_clears_err_h", 32'(err_h), 0);

        // asynchronous reset with a beat pending
        @(negedge clk);
        req_hold = 1'b0;
        send_pix(10'd1, 1'b0, 1'b0);
        send_pix(10'd2, 1'b0, 1'b0);
        rdy_in = 1'b0;
        mon_en = 1'b0;
        #1;
        check("pre_rst_rdy_out", 32'(rdy_out), 1);
        rst_n = 1'b0;
        #1;
        check("arst_req_rdy", 32'({req_out, rdy_out}), 0);
        check("arst_pix_out", 32'(pix_out), 0);
        check("arst_flags", 32'({half_out, last_pix_out, last_line_out, frm_done, err_w, err_h}), 0);
        check("arst_state", 32'(dbg_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_hold = 1'b1;
        rdy_in = 1'b1; pix_in = 10'd5;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            seen = seen | rdy_out | req_out;
        end
        check("idle_no_beat", 32'(seen), 0);
        mon_en = 1'b1;
        exp_q.push_back(bt(1'b0, 1'b0, 1'b0, {10'd6, 10'd5}));
        @(negedge clk);
        pulse_op(1'b0);
        send_pix(10'd5, 1'b0, 1'b0);
        send_pix(10'd6, 1'b0, 1'b0);
        wait_drain();

        // synchronous clear with a beat pending
        req_hold = 1'b0;
        send_pix(10'd7, 1'b0, 1'b0);
        send_pix(10'd8, 1'b0, 1'b0);
        rdy_in = 1'b0;
        mon_en = 1'b0;
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        #1;
        check("soft_rst_rdy_out", 32'(rdy_out), 0);
        check("soft_rst_state", 32'(dbg_state), 0);
        check("soft_rst_pix_out", 32'(pix_out), 0);
        req_hold = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // random frames under random backpressure and input gaps
        bp_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            pulse_op(1'b0);
            run_frame(int'($urandom_range(1, 3)), 0, 1'b1);
            wait_drain();
            check($sformatf("rnd%0d_err_w", f), 32'(err_w), 32'(exp_ew));
            check($sformatf("rnd%0d_err_h", f), 32'(err_h), 32'(exp_eh));
        end
        bp_en = 1'b0;
        repeat (4) @(negedge clk);
        check("frm_done_count", 32'(frm_cnt), 32'(exp_frm));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
